// File: rtl/div_pkg.sv
// Shared definitions for the divider / multiplier pair.
//   DIV_WIDTH   : operand width used by both arithmetic blocks
//   mul_state_t : shift-and-add multiplier control states
package div_pkg;

    localparam int unsigned DIV_WIDTH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } mul_state_t;

endpackage : div_pkg

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: product = multiplicand * multiplier + addend,
// one multiplier bit per clock. Used to rebuild dividend = quotient*divisor + remainder
// so divider results can be self-checked on the board.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   start        request, sampled only while idle
//   multiplicand operand A (WIDTH bits)
//   multiplier   operand B (WIDTH bits), scanned LSB first
//   addend       zero-extended addend (WIDTH bits)
//   busy         high while multiplying
//   valid        one-cycle pulse when product/overflow have just been updated
//   product      2*WIDTH-bit result, held until the next completion
//   overflow     product upper half is non-zero
//
// Build option:
//   EARLY_EXIT_EN  finish as soon as the remaining multiplier bits are all zero.
//                  Results are identical with or without it; only latency changes.
module shift_add_multiplier
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   addend,
    output logic               busy,
    output logic               valid,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_t          state, state_next;
    logic [2*WIDTH-1:0]  acc, acc_next;
    logic [2*WIDTH-1:0]  mc_sh, mc_sh_next;
    logic [WIDTH-1:0]    mp_sh, mp_sh_next;
    logic [CW-1:0]       count, count_next;
    logic [2*WIDTH-1:0]  product_next;
    logic                overflow_next;
    logic                valid_next;

    logic [2*WIDTH-1:0]  sum;
    logic                exit_early;

    // Max result (2^W-1)^2 + (2^W-1) fits in 2W bits, so the adder needs no carry out.
    assign sum = mp_sh[0] ? (acc + mc_sh) : acc;

`ifdef EARLY_EXIT_EN
    assign exit_early = (mp_sh == '0);
`else
    assign exit_early = 1'b0;
`endif

    assign busy = (state == MULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            mc_sh    <= '0;
            mp_sh    <= '0;
            count    <= '0;
            product  <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            mc_sh    <= mc_sh_next;
            mp_sh    <= mp_sh_next;
            count    <= count_next;
            product  <= product_next;
            overflow <= overflow_next;
            valid    <= valid_next;
        end
    end

    always_comb begin
        state_next    = state;
        acc_next      = acc;
        mc_sh_next    = mc_sh;
        mp_sh_next    = mp_sh;
        count_next    = count;
        product_next  = product;
        overflow_next = overflow;
        valid_next    = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_next   = {{WIDTH{1'b0}}, addend};
                    mc_sh_next = {{WIDTH{1'b0}}, multiplicand};
                    mp_sh_next = multiplier;
                    count_next = '0;
                    state_next = MULT;
                end
            end

            MULT: begin
                if (exit_early) begin
                    // Nothing left to add: the accumulator already holds the result.
                    state_next    = IDLE;
                    product_next  = acc;
                    overflow_next = |acc[2*WIDTH-1:WIDTH];
                    valid_next    = 1'b1;
                end else begin
                    acc_next   = sum;
                    mc_sh_next = mc_sh << 1;
                    mp_sh_next = mp_sh >> 1;
                    count_next = count + 1'b1;
                    // Last bit: publish the sum including this edge's partial product.
                    if (count == CW'(WIDTH - 1)) begin
                        state_next    = IDLE;
                        product_next  = sum;
                        overflow_next = |sum[2*WIDTH-1:WIDTH];
                        valid_next    = 1'b1;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule : shift_add_multiplier
